// File: rtl/video_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_csr_pkg
//  Description : Shared register addresses, bit positions and commit-FSM
//                state type for the video core control/status block.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_csr_pkg;

    // Word addresses of the register map
    localparam int CSR_CTRL    = 0;
    localparam int CSR_STATUS  = 1;
    localparam int CSR_ACTIVE  = 2;
    localparam int CSR_SCRATCH = 3;

    // Bit positions inside CTRL and STATUS
    localparam int BYPASS_BIT  = 0;
    localparam int PEND_BIT    = 0;
    localparam int IRQ_BIT     = 1;

    // STATUS field holding the frame counter
    localparam int FCNT_LSB    = 16;
    localparam int FCNT_W      = 16;

    // Commit state machine: a shadow value is either in sync or waiting
    // for the next frame boundary.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } csr_state_t;

endpackage : video_csr_pkg
`default_nettype wire

// File: rtl/video_csr_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : video_csr_shadow
//  Description : Generic shadow/active double buffer. Writes land in the
//                shadow copy; the active copy only changes on a commit
//                request (frame boundary). A write that coincides with the
//                commit request bypasses the shadow wait and commits at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_csr_shadow
    import video_csr_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         commit_req_i,
    output logic [W-1:0] shadow_o,
    output logic [W-1:0] active_o,
    output logic         pending_o,
    output logic         commit_o
);

    csr_state_t   state_q,  state_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] active_q, active_d;
    logic         commit_q, commit_d;

    // State and buffer registers; reset discards any pending value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            commit_q <= commit_d;
        end
    end

    // Next-state logic: same-cycle write+commit wins regardless of state.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        commit_d = 1'b0;
        if (wr_en_i && commit_req_i) begin
            shadow_d = wr_data_i;
            active_d = wr_data_i;
            commit_d = 1'b1;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en_i) begin
                        shadow_d = wr_data_i;
                        state_d  = PENDING;
                    end
                end
                PENDING: begin
                    if (commit_req_i) begin
                        active_d = shadow_q;
                        commit_d = 1'b1;
                        state_d  = IDLE;
                    end else if (wr_en_i) begin
                        shadow_d = wr_data_i;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign shadow_o  = shadow_q;
    assign active_o  = active_q;
    assign pending_o = (state_q == PENDING);
    assign commit_o  = commit_q;

endmodule : video_csr_shadow
`default_nettype wire

// File: rtl/video_core_csr.sv
`default_nettype none
// ============================================================================
//  Module      : video_core_csr
//  Description : Avalon-MM slave CSR block for one video core. CTRL writes
//                are shadowed and committed to core_bypass/core_cfg only at
//                frame_start so a frame is never processed with mixed
//                settings. Reads have a fixed one-cycle latency.
//  Options     : VIDEO_CORE_CSR_IRQ_EN - adds irq output, STATUS.irq_flag
//                set on commit and write-1-to-clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_core_csr
    import video_csr_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 2,
    parameter int CFG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [AW-1:0]    avs_address,
    input  logic             avs_write,
    input  logic [DW-1:0]    avs_writedata,
    input  logic             avs_read,
    output logic [DW-1:0]    avs_readdata,
    output logic             avs_readdatavalid,
    input  logic             frame_start,
    output logic             core_bypass,
    output logic [CFG_W-1:0] core_cfg,
    output logic             commit_pulse
`ifdef VIDEO_CORE_CSR_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int CTRL_W = CFG_W + 1;

    logic              w_ctrl_wr;
    logic              w_status_wr;
    logic              w_scratch_wr;
    logic [CTRL_W-1:0] w_shadow;
    logic [CTRL_W-1:0] w_active;
    logic              w_pending;
    logic              w_commit;
    logic              w_irq_flag;
    logic [31:0]       w_status;
    logic [DW-1:0]     w_rd_mux;

    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]     scratch_q,   scratch_d;
    logic [DW-1:0]     readdata_q,  readdata_d;
    logic              rdvalid_q,   rdvalid_d;

    assign w_ctrl_wr    = avs_write && (avs_address == AW'(CSR_CTRL));
    assign w_status_wr  = avs_write && (avs_address == AW'(CSR_STATUS));
    assign w_scratch_wr = avs_write && (avs_address == AW'(CSR_SCRATCH));

    video_csr_shadow #(
        .W (CTRL_W)
    ) u_shadow (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .wr_en_i      (w_ctrl_wr),
        .wr_data_i    (avs_writedata[CTRL_W-1:0]),
        .commit_req_i (frame_start),
        .shadow_o     (w_shadow),
        .active_o     (w_active),
        .pending_o    (w_pending),
        .commit_o     (w_commit)
    );

    assign core_bypass  = w_active[BYPASS_BIT];
    assign core_cfg     = w_active[CFG_W:1];
    assign commit_pulse = w_commit;

`ifdef VIDEO_CORE_CSR_IRQ_EN
    logic irq_flag_q, irq_flag_d;

    // Sticky commit flag; a set in the same cycle as a clear takes priority.
    always_comb begin
        irq_flag_d = irq_flag_q;
        if (w_status_wr && avs_writedata[IRQ_BIT]) begin
            irq_flag_d = 1'b0;
        end
        if (w_commit) begin
            irq_flag_d = 1'b1;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq_flag_q <= 1'b0;
        end else begin
            irq_flag_q <= irq_flag_d;
        end
    end

    assign w_irq_flag = irq_flag_q;
    assign irq        = irq_flag_q;
`else
    // STATUS writes have no effect in this build.
    assign w_irq_flag = 1'b0;
`endif

    // Frame counter and scratch register next-state.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        scratch_d   = scratch_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (w_scratch_wr) begin
            scratch_d = avs_writedata;
        end
    end

    // STATUS word assembly; counter is truncated/zero-extended to 16 bits.
    always_comb begin
        w_status                           = '0;
        w_status[PEND_BIT]                 = w_pending;
        w_status[IRQ_BIT]                  = w_irq_flag;
        w_status[FCNT_LSB +: FCNT_W]       = FCNT_W'(frame_cnt_q);
    end

    // Read mux sees pre-write state, so a same-cycle write is not visible.
    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            AW'(CSR_CTRL):    w_rd_mux = DW'(w_shadow);
            AW'(CSR_STATUS):  w_rd_mux = DW'(w_status);
            AW'(CSR_ACTIVE):  w_rd_mux = DW'(w_active);
            AW'(CSR_SCRATCH): w_rd_mux = scratch_q;
            default:          w_rd_mux = '0;
        endcase
    end

    // Read response: data is captured only on a strobe and held otherwise.
    always_comb begin
        rdvalid_d  = avs_read;
        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = w_rd_mux;
        end
    end

    // Register bank; frame_start during reset is discarded by priority.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
            scratch_q   <= '0;
            readdata_q  <= '0;
            rdvalid_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            scratch_q   <= scratch_d;
            readdata_q  <= readdata_d;
            rdvalid_q   <= rdvalid_d;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdvalid_q;

endmodule : video_core_csr
`default_nettype wire
